// File: rtl/connection_block_cfg.sv
// Double-buffered connection block: scan-loaded shadow config, committed to the live routing on cfg_load.
// Optional macro CB_CFG_PARITY_EN appends an even-parity bit to the chain and checks it on every load.
module connection_block_cfg #(
    parameter int CHANNEL_ONEWAY_WIDTH = 4,
    parameter int OUTS_PER_SIDE        = 1
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [CHANNEL_ONEWAY_WIDTH-1:0] tracks_0,
    input  logic [CHANNEL_ONEWAY_WIDTH-1:0] tracks_1,
    input  logic                            scan_in,
    input  logic                            scan_en,
    input  logic                            cfg_load,
    output logic                            scan_out,
    output logic [OUTS_PER_SIDE-1:0]        out_0,
    output logic [OUTS_PER_SIDE-1:0]        out_1,
    output logic                            cfg_valid,
    output logic                            cfg_err
);

    localparam int W        = CHANNEL_ONEWAY_WIDTH;
    localparam int N        = OUTS_PER_SIDE;
    localparam int SEL_W    = $clog2(2 * W);
    localparam int FIELD_W  = SEL_W + 1;
    localparam int CFG_BITS = 2 * N * FIELD_W;
`ifdef CB_CFG_PARITY_EN
    localparam int CHAIN_BITS = CFG_BITS + 1;
`else
    localparam int CHAIN_BITS = CFG_BITS;
`endif
    localparam int CNT_W    = $clog2(CHAIN_BITS + 1);

    logic [CHAIN_BITS-1:0] r_shadow;
    logic [CFG_BITS-1:0]   r_active;
    logic [CNT_W-1:0]      r_shift_cnt;
    logic                  r_cfg_valid;
    logic                  r_cfg_err;

    logic                  w_chain_full;
    logic                  w_parity_ok;
    logic                  w_load_req;
    logic                  w_load_ok;
    logic [2*W-1:0]        w_tracks;
    logic [2*N-1:0]        w_route;

    assign w_chain_full = (r_shift_cnt == CNT_W'(CHAIN_BITS));
`ifdef CB_CFG_PARITY_EN
    assign w_parity_ok  = (r_shadow[CHAIN_BITS-1] == ^r_shadow[CFG_BITS-1:0]);
`else
    assign w_parity_ok  = 1'b1;
`endif
    // A load in the same cycle as a shift is never honoured.
    assign w_load_req   = cfg_load & ~scan_en;
    assign w_load_ok    = w_load_req & w_chain_full & w_parity_ok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the shadow chain is reset along with the live config so scan_out is defined out of reset.
            r_shadow    <= '0;
            r_active    <= '0;
            r_shift_cnt <= '0;
            r_cfg_valid <= 1'b0;
            r_cfg_err   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge values of the others.
            if (scan_en) begin
                r_shadow <= {scan_in, r_shadow[CHAIN_BITS-1:1]};
                if (!w_chain_full) begin
                    r_shift_cnt <= r_shift_cnt + CNT_W'(1);
                end
            end
            if (cfg_load) begin
                if (w_load_ok) begin
                    r_active    <= r_shadow[CFG_BITS-1:0];
                    r_cfg_valid <= 1'b1;
                    r_cfg_err   <= 1'b0;
                    r_shift_cnt <= '0;
                end else begin
                    r_cfg_err <= 1'b1;
                    // Full chain but bad parity: force the whole chain to be shifted again.
                    if (w_load_req && w_chain_full) begin
                        r_shift_cnt <= '0;
                    end
                end
            end
        end
    end

    // Picks one bit of the combined channel; disabled or out-of-range selects drive 0.
    function automatic logic route_bit(input logic [FIELD_W-1:0] field,
                                       input logic [2*W-1:0]     tracks);
        logic bit_val;
        // NOTE: default first so no path through the loop leaves bit_val unassigned.
        bit_val = 1'b0;
        for (int j = 0; j < 2 * W; j++) begin
            if (field[SEL_W-1:0] == SEL_W'(j)) begin
                bit_val = tracks[j];
            end
        end
        return bit_val & field[FIELD_W-1];
    endfunction

    assign w_tracks = {tracks_1, tracks_0};

    for (genvar k = 0; k < 2 * N; k++) begin : g_route
        assign w_route[k] = route_bit(r_active[k*FIELD_W +: FIELD_W], w_tracks);
    end

    assign out_0     = w_route[N-1:0];
    assign out_1     = w_route[2*N-1:N];
    assign scan_out  = r_shadow[0];
    assign cfg_valid = r_cfg_valid;
    assign cfg_err   = r_cfg_err;

endmodule

// File: tb/tb_connection_block_cfg.sv
// Bench for connection_block_cfg (W=4, N=1): directed scenarios plus random scan/load traffic
// checked against a queue-based model of the scan chain and a field table for the live routing.
module tb_connection_block_cfg;

    localparam int W        = 4;
    localparam int N        = 1;
    localparam int FIELD_W  = 4;
    localparam int CFG_BITS = 2 * N * FIELD_W;
`ifdef CB_CFG_PARITY_EN
    localparam int CHAIN = CFG_BITS + 1;
`else
    localparam int CHAIN = CFG_BITS;
`endif

    logic         clk;
    logic         rst_n;
    logic [W-1:0] tracks_0;
    logic [W-1:0] tracks_1;
    logic         scan_in;
    logic         scan_en;
    logic         cfg_load;
    logic         scan_out;
    logic [N-1:0] out_0;
    logic [N-1:0] out_1;
    logic         cfg_valid;
    logic         cfg_err;

    connection_block_cfg #(
        .CHANNEL_ONEWAY_WIDTH(W),
        .OUTS_PER_SIDE       (N)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .tracks_0 (tracks_0),
        .tracks_1 (tracks_1),
        .scan_in  (scan_in),
        .scan_en  (scan_en),
        .cfg_load (cfg_load),
        .scan_out (scan_out),
        .out_0    (out_0),
        .out_1    (out_1),
        .cfg_valid(cfg_valid),
        .cfg_err  (cfg_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fails  = 0;

    // Model: chain as a queue (index 0 = scan_out end), live fields as plain integers.
    logic m_chain[$];
    int   m_cnt;
    int   m_active[2*N];
    logic m_valid;
    logic m_err;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_chain.delete();
        for (int i = 0; i < CHAIN; i++) m_chain.push_back(1'b0);
        m_cnt   = 0;
        m_valid = 1'b0;
        m_err   = 1'b0;
        for (int k = 0; k < 2 * N; k++) m_active[k] = 0;
    endtask

    function automatic logic parity_good();
        logic p = 1'b0;
`ifdef CB_CFG_PARITY_EN
        for (int i = 0; i < CFG_BITS; i++) p ^= m_chain[i];
        return p == m_chain[CFG_BITS];
`else
        return 1'b1;
`endif
    endfunction

    task automatic model_clock(input logic se, input logic si, input logic ld);
        if (ld) begin
            if (se) m_err = 1'b1;
            else if (m_cnt == CHAIN && parity_good()) begin
                for (int k = 0; k < 2 * N; k++) begin
                    m_active[k] = 0;
                    for (int b = 0; b < FIELD_W; b++)
                        m_active[k] += int'(m_chain[k*FIELD_W + b]) << b;
                end
                m_valid = 1'b1;
                m_err   = 1'b0;
                m_cnt   = 0;
            end else begin
                m_err = 1'b1;
                if (m_cnt == CHAIN) m_cnt = 0;
            end
        end
        if (se) begin
            m_chain.push_back(si);
            void'(m_chain.pop_front());
            if (m_cnt < CHAIN) m_cnt++;
        end
    endtask

    function automatic logic exp_out(input int k);
        int en  = m_active[k] >> 3;
        int sel = m_active[k] & 7;
        if (en == 0) return 1'b0;
        if (sel < W) return tracks_0[sel];
        if (sel < 2 * W) return tracks_1[sel - W];
        return 1'b0;
    endfunction

    task automatic check_all(input string tag);
        logic [N-1:0] e0, e1;
        for (int k = 0; k < N; k++) begin
            e0[k] = exp_out(k);
            e1[k] = exp_out(k + N);
        end
        check({tag, "_out0"}, 32'(out_0), 32'(e0));
        check({tag, "_out1"}, 32'(out_1), 32'(e1));
        check({tag, "_valid"}, 32'(cfg_valid), 32'(m_valid));
        check({tag, "_err"}, 32'(cfg_err), 32'(m_err));
        check({tag, "_sout"}, 32'(scan_out), 32'(m_chain[0]));
    endtask

    task automatic cycle(input logic se, input logic si, input logic ld, input string tag);
        scan_en  = se;
        scan_in  = si;
        cfg_load = ld;
        @(posedge clk);
        model_clock(se, si, ld);
        #1;
        scan_en  = 1'b0;
        scan_in  = 1'b0;
        cfg_load = 1'b0;
        tracks_0 = W'($urandom);
        tracks_1 = W'($urandom);
        #1;
        check_all(tag);
    endtask

    // Shifts a config word LSB-first, followed by its even-parity bit when the chain carries one.
    task automatic shift_cfg(input logic [CFG_BITS-1:0] val, input string tag);
        for (int i = 0; i < CFG_BITS; i++) cycle(1'b1, val[i], 1'b0, tag);
`ifdef CB_CFG_PARITY_EN
        cycle(1'b1, ^val, 1'b0, tag);
`endif
    endtask

    task automatic apply_reset(input string tag);
        @(negedge clk);
        rst_n    = 1'b0;
        tracks_0 = W'($urandom);
        tracks_1 = W'($urandom);
        #1;
        model_reset();
        check_all(tag);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int nshift;
        rst_n    = 1'b0;
        scan_en  = 1'b0;
        scan_in  = 1'b0;
        cfg_load = 1'b0;
        tracks_0 = W'($urandom);
        tracks_1 = W'($urandom);
        model_reset();

        // 1. Reset state with random tracks.
        #2;
        check_all("t1_reset");
        @(negedge clk);
        rst_n = 1'b1;

        // 2. Basic routing: out_0 en sel=5, out_1 en sel=2.
        shift_cfg(8'b1010_1101, "t2_shift");
        cycle(1'b0, 1'b0, 1'b1, "t2_load");
        check("t2_valid_const", 32'(cfg_valid), 32'd1);
        check("t2_out0_trk", 32'(out_0[0]), 32'(tracks_1[1]));
        check("t2_out1_trk", 32'(out_1[0]), 32'(tracks_0[2]));

        // 3. Double buffering: new config shifted but not yet live.
        shift_cfg(8'b0000_1000, "t3_shift");
        check("t3_hold_out0", 32'(out_0[0]), 32'(tracks_1[1]));
        check("t3_hold_out1", 32'(out_1[0]), 32'(tracks_0[2]));
        cycle(1'b0, 1'b0, 1'b1, "t3_load");
        check("t3_new_out0", 32'(out_0[0]), 32'(tracks_0[0]));
        check("t3_new_out1", 32'(out_1[0]), 32'd0);

        // 4. Partial-chain rejection, then completion.
        apply_reset("t4_reset");
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'($urandom), 1'b0, "t4_shift5");
        cycle(1'b0, 1'b0, 1'b1, "t4_reject");
        check("t4_err_const", 32'(cfg_err), 32'd1);
        check("t4_valid_const", 32'(cfg_valid), 32'd0);
        for (int i = 5; i < CHAIN; i++) cycle(1'b1, 1'($urandom), 1'b0, "t4_shift_rest");
        cycle(1'b0, 1'b0, 1'b1, "t4_accept");
        check("t4_err_clr", 32'(cfg_err), 32'd0);

        // 5. Load during shift is rejected; the chain then streams a random word through.
        shift_cfg(8'b1100_1011, "t5_shift");
        cycle(1'b1, 1'b1, 1'b1, "t5_load_shift");
        check("t5_err_const", 32'(cfg_err), 32'd1);
        for (int i = 0; i < 2 * CHAIN; i++) cycle(1'b1, 1'($urandom), 1'b0, "t5_stream");

`ifdef CB_CFG_PARITY_EN
        // 6. Parity accept, then flipped parity rejected with active config held.
        apply_reset("t6_reset");
        shift_cfg(8'b1010_1101, "t6_shift");
        cycle(1'b0, 1'b0, 1'b1, "t6_accept");
        check("t6_err_ok", 32'(cfg_err), 32'd0);
        for (int i = 0; i < CFG_BITS; i++) cycle(1'b1, 1'(8'hA2 >> i), 1'b0, "t6_bad_shift");
        cycle(1'b1, 1'b0, 1'b0, "t6_bad_par");
        cycle(1'b0, 1'b0, 1'b1, "t6_reject");
        check("t6_err_bad", 32'(cfg_err), 32'd1);
        check("t6_hold_out0", 32'(out_0[0]), 32'(tracks_1[1]));
        cycle(1'b0, 1'b0, 1'b1, "t6_cnt_cleared");
`endif

        // Asynchronous reset in the middle of a shift.
        shift_cfg(8'b1001_1110, "ar_shift");
        cycle(1'b0, 1'b0, 1'b1, "ar_load");
        scan_en = 1'b1;
        scan_in = 1'b1;
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("ar_mid");
        check("ar_out0_zero", 32'(out_0), 32'd0);
        #2;
        rst_n   = 1'b1;
        scan_en = 1'b0;
        scan_in = 1'b0;

        // Random traffic: bursts of shifts with stray loads, each followed by a load attempt.
        for (int it = 0; it < 40; it++) begin
            nshift = $urandom_range(0, CHAIN + 4);
            for (int i = 0; i < nshift; i++)
                cycle(1'b1, 1'($urandom), ($urandom_range(0, 11) == 0), "rnd_shift");
            cycle(1'b0, 1'b0, 1'b1, "rnd_load");
            for (int i = 0; i < 2; i++) cycle(1'b0, 1'b0, 1'b0, "rnd_idle");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
